dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder side of the pipeline's data-memory request interface.
- The MEM stage issues load/store requests. This block accepts one request at a time, waits a programmable number of cycles to model memory latency, performs the access on internal word storage, and returns a response.
- The pipeline stalls on an outstanding request. This block never stalls on its own behalf beyond its latency.

Parameters:
- DEPTH, 256, number of 32-bit words of storage; valid word index 0..DEPTH-1.
- LATENCY, 2, wait cycles between request acceptance and the access; range 0..15.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i writes byte i (little-endian lanes).
- resp_valid  output  1  response present.
- resp_ready  input  1  pipeline accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.
- busy  output  1  request accepted but its response not yet consumed.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, counter=0, captured request cleared.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - Storage contents are not reset.
  - Reset mid-operation abandons the request. No write occurs unless the write edge already happened before reset.
- Handshakes:
  - A request is accepted when req_valid & req_ready at a clk edge. All req_* fields are captured at that edge.
  - A response is consumed when resp_valid & resp_ready at a clk edge.
  - req_ready=1 only in IDLE, so there is at most one outstanding request and no pipelining.
- State machine (IDLE, WAIT, RESP):
  - IDLE: on acceptance, go to WAIT with counter=LATENCY-1 if LATENCY>0. If LATENCY=0, perform the access at the acceptance edge and go to RESP.
  - WAIT: if counter=0, perform the access at this edge and go to RESP; otherwise decrement the counter.
  - RESP: resp_valid=1. resp_rdata and resp_err stay stable until consumed. On consumption, return to IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
  - No request may be accepted in the consumption cycle; the next acceptance is one cycle later.
- Latency: acceptance edge to first resp_valid=1 cycle is exactly LATENCY+1 cycles.
- busy = (state != IDLE).
- Access rules:
  - word index = req_addr[31:2].
  - Error if req_addr[1:0] != 0, or if index >= DEPTH. Upper address bits beyond the index range count as out of range; there is no wrap-around.
  - Error response: resp_err=1, resp_rdata=0, no storage modification.
  - Load: resp_rdata = mem[index]; req_be is ignored.
  - Store: only enabled bytes are updated; resp_rdata=0, resp_err=0. req_be=0000 is a legal no-op store and still gets a response.
- Inputs while not ready are ignored; req_* may change freely when req_ready=0.
- resp_ready held high while resp_valid=0 has no effect.
- An X on req_valid during reset is don't-care.

Test Plan:
- Store then load, LATENCY=2: store addr 0x10, data 0xDEADBEEF, be=1111. resp_valid rises 3 cycles after acceptance with err=0, rdata=0. Then load 0x10: rdata=0xDEADBEEF, err=0, 3 cycles after acceptance.
- Byte enables: store 0x11223344 to 0x20, then store 0xAABBCCDD with be=0101, then load 0x20 → 0x11BB33DD.
- Errors:
  - Load 0x22 → err=1, rdata=0.
  - Store to 4*DEPTH (0x400 at DEPTH=256) → err=1, then load 0x0 is unchanged from its prior value.
  - Load 0x3FC → err=0.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP. resp_valid, rdata and err stay stable and req_ready=0 throughout. A req_valid pulse during this window is not accepted and causes no write.
- LATENCY=0 instance: load accepted at edge N gives resp_valid=1 in the cycle after edge N. Back-to-back requests with resp_ready=1 continuously are accepted every 2 cycles.
- Reset mid-WAIT: accept a store of 0x12345678 to 0x40 over old value 0xCAFEF00D, then assert rst_n=0 during WAIT. After reset, outputs are at their reset values. A following load of 0x40 returns 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// performs the word access on internal storage and holds the response until consumed.
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state, state_next;
   logic [3:0]      counter;
   logic            cap_we;
   logic [AW-1:0]   cap_idx;
   logic [31:0]     cap_wdata;
   logic [3:0]      cap_be;
   logic            cap_err;
   logic [31:0]     mem [DEPTH];

   logic            accept, consume, do_access, req_err;
   logic            acc_we, acc_err;
   logic [AW-1:0]   acc_idx;
   logic [31:0]     acc_wdata;
   logic [3:0]      acc_be;

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);
   assign accept     = req_valid & req_ready;
   assign consume    = resp_valid & resp_ready;

   // Any address bit above the index range makes the request out of range (no wrap).
   assign req_err = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

   // With zero latency the access happens at the acceptance edge, straight from the request.
   always_comb begin
      acc_we    = cap_we;
      acc_err   = cap_err;
      acc_idx   = cap_idx;
      acc_wdata = cap_wdata;
      acc_be    = cap_be;
      if (state == IDLE) begin
         acc_we    = req_we;
         acc_err   = req_err;
         acc_idx   = req_addr[AW+1:2];
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end
   end

   always_comb begin
      state_next = state;
      do_access  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  do_access  = 1'b1;
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (counter == 4'd0) begin
               do_access  = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (consume) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         counter    <= 4'd0;
         cap_we     <= 1'b0;
         cap_idx    <= '0;
         cap_wdata  <= 32'd0;
         cap_be     <= 4'd0;
         cap_err    <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            counter   <= 4'(LATENCY - 1);
            cap_we    <= req_we;
            cap_idx   <= req_addr[AW+1:2];
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            cap_err   <= req_err;
         end else if (state == WAIT && counter != 4'd0) begin
            counter <= counter - 4'd1;
         end
         if (do_access) begin
            resp_err   <= acc_err;
            resp_rdata <= (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
         end else if (consume) begin
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
         end
      end
   end

   // Storage is deliberately left out of reset; a reset edge suppresses a pending write.
   always_ff @(posedge clk) begin
      if (rst_n && do_access && acc_we && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against an array-based memory model,
// with a second zero-latency instance for back-to-back throughput.
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid, resp_ready, resp_err, busy;
   logic [31:0] resp_rdata;

   logic        z_req_valid, z_req_ready, z_req_we;
   logic [31:0] z_req_addr, z_req_wdata;
   logic [3:0]  z_req_be;
   logic        z_resp_valid, z_resp_ready, z_resp_err, z_busy;
   logic [31:0] z_resp_rdata;

   int          checkCount = 0;
   int          errorCount = 0;
   logic [31:0] model [DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
   );

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
      .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
      .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
      .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic isErr(input logic [31:0] addr);
      return (addr % 4 != 0) || ((addr / 4) >= 32'(DEPTH));
   endfunction

   // Drives one request, checks latency, holds the response for 'hold' cycles, then consumes it.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input int hold, input bit junk,
                                output logic [31:0] gotData, output logic gotErr);
      logic [31:0] expData;
      logic        expErr;
      int          idx;
      expErr  = isErr(addr);
      idx     = expErr ? 0 : int'(addr / 4);
      expData = (!we && !expErr) ? model[idx] : 32'd0;
      @(negedge clk);
      checkOutput("req_ready idle", req_ready, 1);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      req_be     = be;
      resp_ready = (hold == 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      if (we && !expErr) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
      end
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge clk);
         checkOutput("resp_valid latency", resp_valid, (k == LAT + 1) ? 1 : 0);
         checkOutput("busy outstanding", busy, 1);
         checkOutput("req_ready outstanding", req_ready, 0);
      end
      gotData = resp_rdata;
      gotErr  = resp_err;
      checkOutput("resp_rdata", resp_rdata, expData);
      checkOutput("resp_err", resp_err, expErr);
      for (int h = 0; h < hold; h++) begin
         if (junk && h == 1) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = addr;
            req_wdata = ~wdata;
            req_be    = 4'hF;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
         checkOutput("held resp_valid", resp_valid, 1);
         checkOutput("held resp_rdata", resp_rdata, expData);
         checkOutput("held resp_err", resp_err, expErr);
         checkOutput("held req_ready", req_ready, 0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("consumed resp_valid", resp_valid, 0);
      checkOutput("consumed resp_rdata", resp_rdata, 0);
      checkOutput("consumed resp_err", resp_err, 0);
      checkOutput("consumed req_ready", req_ready, 1);
      checkOutput("consumed busy", busy, 0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " req_ready"}, req_ready, 1);
      checkOutput({tag, " resp_valid"}, resp_valid, 0);
      checkOutput({tag, " resp_rdata"}, resp_rdata, 0);
      checkOutput({tag, " resp_err"}, resp_err, 0);
      checkOutput({tag, " busy"}, busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] d, prior, zval, a;
      logic        e;
      int          accepts, r;

      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
      resp_ready = 1'b0;
      z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
      z_resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      checkOutput("reset z_req_ready", z_req_ready, 1);
      checkOutput("reset z_resp_valid", z_resp_valid, 0);
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0, d, e);

      applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, d, e);
      checkOutput("store 0x10 err", e, 0);
      checkOutput("store 0x10 rdata", d, 0);
      applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, d, e);
      checkOutput("load 0x10", d, 32'hDEADBEEF);

      applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, d, e);
      applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0, d, e);
      applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, d, e);
      checkOutput("byte enable merge", d, 32'h11BB33DD);

      applyStimulus(1'b0, 32'h22, 32'h0, 4'hF, 0, 1'b0, d, e);
      checkOutput("misaligned err", e, 1);
      checkOutput("misaligned rdata", d, 0);
      prior = model[0];
      applyStimulus(1'b1, 32'(DEPTH * 4), 32'h55AA55AA, 4'hF, 1, 1'b0, d, e);
      checkOutput("out of range err", e, 1);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, d, e);
      checkOutput("word 0 untouched", d, prior);
      applyStimulus(1'b0, 32'(DEPTH * 4 - 4), 32'h0, 4'h0, 0, 1'b0, d, e);
      checkOutput("last word err", e, 0);

      applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, d, e);
      applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, d, e);
      checkOutput("no write under backpressure", d, 32'hDEADBEEF);

      for (int t = 0; t < 80; t++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
         else if (r < 8) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
         else if (r < 9) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000)) * 4;
         else            a = $urandom | 32'h8000_0000;
         applyStimulus(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3),
                       1'($urandom), d, e);
      end

      applyStimulus(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 1'b0, d, e);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678; req_be = 4'hF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("wait busy before reset", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetOutputs("mid-wait reset");
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, d, e);
      checkOutput("abandoned store", d, 32'hCAFEF00D);

      zval = $urandom;
      @(negedge clk);
      z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h8; z_req_wdata = zval; z_req_be = 4'hF;
      z_resp_ready = 1'b1;
      @(posedge clk);
      #1;
      z_req_valid = 1'b0;
      @(negedge clk);
      checkOutput("lat0 store resp_valid", z_resp_valid, 1);
      checkOutput("lat0 store err", z_resp_err, 0);
      @(negedge clk);
      checkOutput("lat0 consumed", z_resp_valid, 0);
      z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h8; z_req_be = 4'h0;
      accepts = 0;
      for (int i = 0; i < 12; i++) begin
         if (z_req_ready) begin
            accepts++;
         end else begin
            checkOutput("lat0 resp_valid", z_resp_valid, 1);
            checkOutput("lat0 load rdata", z_resp_rdata, zval);
         end
         @(negedge clk);
      end
      z_req_valid = 1'b0;
      checkOutput("lat0 accepts in 12 cycles", 32'(accepts), 6);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
